// File: rtl/tape_burst_reader.sv
// Burst-based tape image fetcher: pulls the image from DDR through the IPIF master
// in multi-word bursts into a word FIFO and presents it as a byte stream.
module tape_burst_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
    parameter int          BURST_WORDS = 16,
    parameter int          FIFO_DEPTH  = 64,
    parameter bit          SWAP_BYTES  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [23:0] file_len,
    input  logic        read,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        eof,
    output logic [23:0] bytes_read,
    output logic [31:0] ip2bus_mst_addr,
    output logic [11:0] ip2bus_mst_length,
    output logic        mstread_req,
    output logic        mst_type,
    output logic        mst_dst_rdy_n,
    input  logic        cmd_ack,
    input  logic        mst_src_rdy_n,
    input  logic [31:0] ip2bus_mstrd_d
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0]  BURST_B = 7'(BURST_WORDS);
    localparam logic [22:0] BURST_W = 23'(BURST_WORDS);
    localparam logic [AW:0] DEPTH_F = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] BURST_F = (AW + 1)'(BURST_WORDS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, FLUSH} state_t;
    state_t state_q, state_d;

    logic        init_q;
    logic [23:0] len_q, len_eff;
    logic [22:0] words_left_q, words_init;
    logic [31:0] addr_q, cmd_addr_q;
    logic [11:0] cmd_len_q;
    logic [6:0]  beats_q, beats_d, beat_cnt_q;
    logic        flush_pend_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q, fill, used;
    logic        wr_vld_q;
    logic [31:0] wr_data_q;
    logic [31:0] mem [FIFO_DEPTH];
    logic [1:0]  lane_q;
    logic [23:0] bytes_read_q;
    logic        load, beat, beat_last, launch, space_ok;
    logic        fifo_empty, pop, last_byte, pop_word;
    logic [31:0] head;
    logic [7:0]  head_byte;

    // The first cycle after reset release behaves like a restart so file_len is latched.
    assign load       = restart | init_q;
    assign len_eff    = init_q ? file_len : len_q;
    assign words_init = 23'((25'(file_len) + 25'd3) >> 2);
    assign beats_d    = (words_left_q >= BURST_W) ? BURST_B : words_left_q[6:0];

    // The word sitting in the write register still occupies a FIFO slot.
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign used     = fill + {{AW{1'b0}}, wr_vld_q};
    assign space_ok = (DEPTH_F - used) >= BURST_F;

    assign beat      = ((state_q == DATA) || (state_q == FLUSH)) && !mst_src_rdy_n;
    assign beat_last = beat && (beat_cnt_q == beats_q - 7'd1);
    assign launch    = (state_q == IDLE) && (state_d == CMD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!load && (words_left_q != '0) && space_ok) state_d = CMD;
            CMD:     if (cmd_ack) state_d = (flush_pend_q || restart) ? FLUSH : DATA;
            DATA:    if (beat_last) state_d = IDLE;
                     else if (restart) state_d = FLUSH;
            FLUSH:   if (beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mstread_req   = (state_q == CMD);
        mst_type      = (state_q == CMD);
        mst_dst_rdy_n = !((state_q == DATA) || (state_q == FLUSH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q       <= 1'b1;
            len_q        <= '0;
            words_left_q <= '0;
            addr_q       <= BASE_ADDR;
            cmd_addr_q   <= BASE_ADDR;
            cmd_len_q    <= '0;
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            init_q <= 1'b0;
            if (launch) begin
                beats_q    <= beats_d;
                cmd_addr_q <= addr_q;
                cmd_len_q  <= {3'b000, beats_d, 2'b00};
            end
            if ((state_q == CMD) && cmd_ack) beat_cnt_q <= '0;
            else if (beat)                   beat_cnt_q <= beat_cnt_q + 7'd1;
            // A restart during CMD leaves the held burst to be drained as FLUSH.
            if ((state_q != CMD) || cmd_ack) flush_pend_q <= 1'b0;
            else if (restart)                flush_pend_q <= 1'b1;
            if (load) begin
                len_q        <= file_len;
                words_left_q <= words_init;
                addr_q       <= BASE_ADDR;
            end else if ((state_q == CMD) && cmd_ack && !flush_pend_q) begin
                words_left_q <= words_left_q - {16'd0, beats_q};
                addr_q       <= addr_q + {23'd0, beats_q, 2'b00};
            end
        end
    end

    assign fifo_empty = (fill == '0);
    assign eof        = (bytes_read_q == len_eff);
    assign empty      = fifo_empty | eof;
    assign pop        = read & !empty;
    assign last_byte  = ((bytes_read_q + 24'd1) == len_eff);
    assign pop_word   = pop & ((lane_q == 2'd3) | last_byte);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_vld_q     <= 1'b0;
            lane_q       <= '0;
            bytes_read_q <= '0;
        end else if (load) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_vld_q     <= 1'b0;
            lane_q       <= '0;
            bytes_read_q <= '0;
        end else begin
            wr_vld_q <= beat && (state_q == DATA);
            if (wr_vld_q) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_word) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop) begin
                bytes_read_q <= bytes_read_q + 24'd1;
                lane_q       <= pop_word ? 2'd0 : lane_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) wr_data_q <= ip2bus_mstrd_d;
        if (wr_vld_q && !load) mem[wr_ptr_q[AW-1:0]] <= wr_data_q;
    end

    assign head = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        head_byte = '0;
        case (SWAP_BYTES ? lane_q : ~lane_q)
            2'd0: head_byte = head[7:0];
            2'd1: head_byte = head[15:8];
            2'd2: head_byte = head[23:16];
            2'd3: head_byte = head[31:24];
            default: head_byte = '0;
        endcase
    end

    assign dout              = empty ? 8'd0 : head_byte;
    assign bytes_read        = bytes_read_q;
    assign ip2bus_mst_addr   = cmd_addr_q;
    assign ip2bus_mst_length = cmd_len_q;

endmodule

// File: tb/tb_tape_burst_reader.sv
// Bench for tape_burst_reader: a DDR memory model answers IPIF bursts with random
// handshake timing; the byte stream and command list are predicted from the image rules.
`define CHK(tag, obs, exp) \
    begin \
        n_tests++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_tape_burst_reader;
    localparam logic [31:0] BASE = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        read = 1'b0;
    logic [23:0] file_len = '0;
    logic        cmd_ack = 1'b0;
    logic        mst_src_rdy_n = 1'b1;
    logic [31:0] ip2bus_mstrd_d = '0;
    logic [7:0]  dout;
    logic        empty, eof, mstread_req, mst_type, mst_dst_rdy_n;
    logic [23:0] bytes_read;
    logic [31:0] ip2bus_mst_addr;
    logic [11:0] ip2bus_mst_length;

    int n_tests = 0;
    int n_fail = 0;
    int fixed_dly = -1;
    int rdy_pct = 60;
    int stab_bad = 0;
    int rdy_bad = 0;
    int type_bad = 0;
    int beat_cnt = 0;
    int k;
    logic [31:0] cq_addr[$];
    logic [11:0] cq_len[$];

    tape_burst_reader dut (
        .clk(clk), .reset(reset), .restart(restart), .file_len(file_len), .read(read),
        .dout(dout), .empty(empty), .eof(eof), .bytes_read(bytes_read),
        .ip2bus_mst_addr(ip2bus_mst_addr), .ip2bus_mst_length(ip2bus_mst_length),
        .mstread_req(mstread_req), .mst_type(mst_type), .mst_dst_rdy_n(mst_dst_rdy_n),
        .cmd_ack(cmd_ack), .mst_src_rdy_n(mst_src_rdy_n), .ip2bus_mstrd_d(ip2bus_mstrd_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    // Image byte idx: low byte of each little-endian word first.
    function automatic logic [7:0] exp_byte(input int idx);
        logic [31:0] w;
        w = mem_word(BASE + 32'(4 * (idx / 4)));
        return w[8 * (idx % 4) +: 8];
    endfunction

    always @(posedge clk) if (!mst_src_rdy_n && !mst_dst_rdy_n) beat_cnt <= beat_cnt + 1;

    // DDR / IPIF master model.
    initial begin : responder
        logic [31:0] a;
        logic [11:0] l;
        int d, n, i;
        forever begin
            @(negedge clk);
            if (reset && mstread_req) begin
                a = ip2bus_mst_addr;
                l = ip2bus_mst_length;
                cq_addr.push_back(a);
                cq_len.push_back(l);
                if (mst_type !== 1'b1) type_bad++;
                d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 6));
                repeat (d) begin
                    @(negedge clk);
                    if (mstread_req !== 1'b1 || ip2bus_mst_addr !== a || ip2bus_mst_length !== l)
                        stab_bad++;
                end
                cmd_ack = 1'b1;
                @(negedge clk);
                cmd_ack = 1'b0;
                if (mstread_req !== 1'b0) stab_bad++;
                n = int'(l) / 4;
                i = 0;
                while (i < n) begin
                    if (mst_dst_rdy_n !== 1'b0) rdy_bad++;
                    if ($urandom_range(0, 99) < rdy_pct) begin
                        mst_src_rdy_n  = 1'b0;
                        ip2bus_mstrd_d = mem_word(a + 32'(4 * i));
                    end else begin
                        mst_src_rdy_n  = 1'b1;
                        ip2bus_mstrd_d = ~mem_word(a + 32'(4 * i));
                    end
                    @(negedge clk);
                    if (!mst_src_rdy_n) i++;
                end
                mst_src_rdy_n = 1'b1;
            end
        end
    end

    task automatic run_read(input int k_end, input bit random_rd, input int budget);
        int cyc;
        bit rd;
        cyc = 0;
        while (k < k_end && cyc < budget) begin
            rd = random_rd ? ($urandom_range(0, 99) < 70) : 1'b1;
            if (rd && !empty) begin
                `CHK("dout", dout, exp_byte(k))
                k++;
            end
            read = rd;
            @(negedge clk);
            cyc++;
        end
        read = 1'b0;
        `CHK("bytes_reached", k, k_end)
    endtask

    task automatic check_cmds(input int s, input int flen);
        int words, nb, rem;
        words = (flen + 3) / 4;
        nb = (words + 15) / 16;
        `CHK("n_cmds", cq_addr.size() - s, nb)
        for (int b = 0; b < nb && s + b < cq_addr.size(); b++) begin
            rem = words - 16 * b;
            `CHK("cmd_addr", cq_addr[s + b], BASE + 32'(64 * b))
            `CHK("cmd_len", cq_len[s + b], 12'(4 * ((rem < 16) ? rem : 16)))
        end
    endtask

    task automatic pulse_restart(input logic [23:0] len);
        file_len = len;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        int s, b0, cyc;
        file_len = 24'd256;
        repeat (3) @(negedge clk);
        `CHK("rst_req", mstread_req, 1'b0)
        `CHK("rst_type", mst_type, 1'b0)
        `CHK("rst_dst_rdy_n", mst_dst_rdy_n, 1'b1)
        `CHK("rst_addr", ip2bus_mst_addr, BASE)
        `CHK("rst_len", ip2bus_mst_length, 12'd0)
        `CHK("rst_dout", dout, 8'd0)
        `CHK("rst_empty", empty, 1'b1)
        `CHK("rst_eof", eof, 1'b0)
        `CHK("rst_bytes", bytes_read, 24'd0)
        reset = 1'b1;
        @(negedge clk);

        // 256-byte image, read held high.
        k = 0;
        run_read(256, 1'b0, 3000);
        `CHK("t1_eof", eof, 1'b1)
        `CHK("t1_empty", empty, 1'b1)
        `CHK("t1_bytes", bytes_read, 24'd256)
        check_cmds(0, 256);

        // 70-byte image: short final burst, byte 71 blocked.
        s = cq_addr.size();
        pulse_restart(24'd70);
        `CHK("t2_bytes0", bytes_read, 24'd0)
        `CHK("t2_eof0", eof, 1'b0)
        k = 0;
        run_read(70, 1'b1, 3000);
        read = 1'b1;
        repeat (10) @(negedge clk);
        read = 1'b0;
        `CHK("t2_bytes", bytes_read, 24'd70)
        `CHK("t2_empty", empty, 1'b1)
        `CHK("t2_eof", eof, 1'b1)
        check_cmds(s, 70);

        // 200-word image with read low: fetching stalls on a full FIFO.
        s = cq_addr.size();
        pulse_restart(24'd800);
        k = 0;
        repeat (600) @(negedge clk);
        `CHK("t3_cmds_full", cq_addr.size() - s, 4)
        `CHK("t3_req_idle", mstread_req, 1'b0)
        `CHK("t3_not_empty", empty, 1'b0)
        run_read(60, 1'b1, 2000);
        repeat (100) @(negedge clk);
        `CHK("t3_cmds_15w", cq_addr.size() - s, 4)
        run_read(64, 1'b0, 200);
        cyc = 0;
        while (cq_addr.size() - s < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        `CHK("t3_cmds_16w", cq_addr.size() - s, 5)
        run_read(800, 1'b1, 6000);
        `CHK("t3_eof", eof, 1'b1)
        check_cmds(s, 800);

        // Restart (with a simultaneous read) at beat 5 of the first burst.
        s = cq_addr.size();
        pulse_restart(24'd256);
        b0 = beat_cnt;
        cyc = 0;
        while (beat_cnt < b0 + 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        `CHK("t4_beat5", (beat_cnt >= b0 + 5), 1'b1)
        restart = 1'b1;
        read = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        read = 1'b0;
        `CHK("t4_bytes0", bytes_read, 24'd0)
        k = 0;
        run_read(256, 1'b1, 4000);
        `CHK("t4_ncmds", cq_addr.size() - s, 5)
        `CHK("t4_flush_addr", cq_addr[s], BASE)
        `CHK("t4_flush_len", cq_len[s], 12'd64)
        check_cmds(s + 1, 256);

        // Slow command acceptance.
        fixed_dly = 20;
        s = cq_addr.size();
        pulse_restart(24'd300);
        k = 0;
        run_read(300, 1'b1, 6000);
        `CHK("t5_eof", eof, 1'b1)
        check_cmds(s, 300);
        fixed_dly = -1;
        `CHK("cmd_stable", stab_bad, 0)
        `CHK("dst_rdy_low", rdy_bad, 0)
        `CHK("mst_type", type_bad, 0)

        // Empty image from reset.
        file_len = 24'd0;
        reset = 1'b0;
        @(negedge clk);
        `CHK("z_rst_eof", eof, 1'b1)
        `CHK("z_rst_empty", empty, 1'b1)
        reset = 1'b1;
        s = cq_addr.size();
        repeat (60) @(negedge clk);
        `CHK("z_no_cmd", cq_addr.size(), s)
        `CHK("z_req", mstread_req, 1'b0)
        `CHK("z_eof", eof, 1'b1)
        `CHK("z_empty", empty, 1'b1)
        `CHK("z_bytes", bytes_read, 24'd0)

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`undef CHK
